csr_file: RTL and testbench

Machine-mode control and status register block for the single-cycle RV32I core. It sits beside the integer register file and closes the CSR loop. It consumes the rs1 operand (or the zero-extended immediate) that the register file supplies, returns the old CSR value for the register file write-back path, and redirects the PC on interrupt entry and `mret`. It also owns the free-running cycle counter and the interrupt-enable/pending state.

---
 rtl/csr_file.sv | 191 +++++++++++++++++++
 tb/tb_csr_file.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file
//
// Machine-mode CSR block for the single-cycle RV32I core. Holds mstatus
// (MIE/MPIE), mie, mtvec, mepc, mcause, the registered mip copy of the
// interrupt lines and a free-running 64-bit cycle counter. It performs
// CSR read-modify-write, takes timer/external interrupts and handles mret.
//
// Ports
//   clk, rst_n    : core clock, asynchronous active-low reset
//   csr_rd        : instruction reads a CSR (read data is always driven)
//   csr_wr        : instruction writes a CSR
//   csr_op        : 01 write, 10 set, 11 clear, 00 none
//   csr_addr      : CSR address
//   csr_wdata     : rs1 value or zimm, already selected
//   csr_rdata     : pre-write value of the addressed CSR (combinational)
//   pc            : PC of the current instruction
//   instr_valid   : current instruction may retire
//   is_mret       : current instruction is mret
//   timer_irq     : machine timer interrupt line (level)
//   ext_irq       : machine external interrupt line (level)
//   epc_taken     : redirect the PC this cycle (combinational)
//   epc_out       : redirect target (combinational)
//
// Handshake: there is no valid/ready pair here. An instruction is presented
// for exactly one cycle; instr_valid qualifies every state change, and all
// effects of that instruction commit at the next rising clock edge.
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] pc,
  input  logic        instr_valid,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic        epc_taken,
  output logic [31:0] epc_out
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  logic        st_mie;
  logic        st_mpie;
  logic        en_mtie;
  logic        en_meie;
  logic        mip_mtip;
  logic        mip_meip;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] cycle_q;
  logic [63:0] cycle_nxt;

  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic        ext_pend;
  logic        tmr_pend;
  logic        trap;
  logic        mret_go;
  logic        wr_en;
  logic [3:0]  cause_code;
  logic [31:0] trap_cause;
  logic [31:0] tvec_base;
  logic [31:0] trap_target;

  // Read data does not depend on csr_rd, and pc[1:0] is dropped because
  // mepc is always word aligned.
  logic unused_ok;
  assign unused_ok = ^{csr_rd, pc[1:0]};

  // Read mux: unimplemented addresses return zero.
  always_comb begin
    rd_val = '0;
    case (csr_addr)
      ADDR_MSTATUS: rd_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      ADDR_MIE:     rd_val = {20'b0, en_meie, 3'b0, en_mtie, 7'b0};
      ADDR_MTVEC:   rd_val = mtvec_q;
      ADDR_MEPC:    rd_val = mepc_q;
      ADDR_MCAUSE:  rd_val = mcause_q;
      ADDR_MIP:     rd_val = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
      ADDR_MCYCLE:  rd_val = cycle_q[31:0];
      ADDR_MCYCLEH: rd_val = cycle_q[63:32];
      default:      rd_val = '0;
    endcase
  end

  assign csr_rdata = rd_val;

  // Unmasked new value; each register applies its own mask on commit.
  always_comb begin
    wr_val = rd_val;
    case (csr_op)
      2'b01:   wr_val = csr_wdata;
      2'b10:   wr_val = rd_val | csr_wdata;
      2'b11:   wr_val = rd_val & ~csr_wdata;
      default: wr_val = rd_val;
    endcase
  end

  // Interrupt decision uses the registered mip copy, not the raw lines.
  assign ext_pend   = st_mie & en_meie & mip_meip;
  assign tmr_pend   = st_mie & en_mtie & mip_mtip;
  assign trap       = instr_valid & (ext_pend | tmr_pend);
  assign mret_go    = instr_valid & is_mret & ~trap;
  assign wr_en      = csr_wr & instr_valid & (csr_op != 2'b00) & ~trap;

  assign cause_code  = ext_pend ? 4'd11 : 4'd7;
  assign trap_cause  = {1'b1, 27'b0, cause_code};
  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  // Vectored mode offsets by 4 x cause; the interrupt bit shifts out of
  // the 32-bit sum, so only the cause code contributes.
  assign trap_target = mtvec_q[0] ? (tvec_base + {26'b0, cause_code, 2'b00})
                                  : tvec_base;

  assign epc_taken = trap | mret_go;
  assign epc_out   = trap ? trap_target : (mret_go ? mepc_q : 32'h0);

  // Counter: a software write to one half replaces that half's increment;
  // the other half keeps counting, carry included.
  always_comb begin
    cycle_nxt = cycle_q + 64'd1;
    if (wr_en && (csr_addr == ADDR_MCYCLE)) begin
      cycle_nxt[31:0] = wr_val;
    end
    if (wr_en && (csr_addr == ADDR_MCYCLEH)) begin
      cycle_nxt[63:32] = wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      en_mtie  <= 1'b0;
      en_meie  <= 1'b0;
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
      cycle_q  <= '0;
    end else begin
      mip_mtip <= timer_irq;
      mip_meip <= ext_irq;
      cycle_q  <= cycle_nxt;

      if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            st_mie  <= wr_val[3];
            st_mpie <= wr_val[7];
          end
          ADDR_MIE: begin
            en_mtie <= wr_val[7];
            en_meie <= wr_val[11];
          end
          ADDR_MTVEC:  mtvec_q  <= {wr_val[31:2], 1'b0, wr_val[0]};
          ADDR_MEPC:   mepc_q   <= {wr_val[31:2], 2'b00};
          ADDR_MCAUSE: mcause_q <= wr_val;
          default: ;
        endcase
      end

      // mret overrides a same-cycle mstatus write; a trap blocks both.
      if (trap) begin
        mepc_q   <= {pc[31:2], 2'b00};
        mcause_q <= trap_cause;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret_go) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file
//
// Directed steps followed by a randomized run, all compared against a
// behavioural model of the CSR block held as plain variables updated with
// arithmetic once per clock edge.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0400;

  logic        clk;
  logic        rst_n;
  logic        csr_rd;
  logic        csr_wr;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] pc;
  logic        instr_valid;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic        epc_taken;
  logic [31:0] epc_out;

  int n_assert;
  int n_fail;

  // Reference model state
  logic [31:0] m_status;
  logic [31:0] m_mie;
  logic [31:0] m_mtvec;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mip;
  logic [63:0] m_cycle;

  csr_file #(.MTVEC_RST(MTVEC_RST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_rd      (csr_rd),
    .csr_wr      (csr_wr),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .pc          (pc),
    .instr_valid (instr_valid),
    .is_mret     (is_mret),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .epc_taken   (epc_taken),
    .epc_out     (epc_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h0000_1800;
    m_mie    = 32'h0;
    m_mtvec  = MTVEC_RST;
    m_mepc   = 32'h0;
    m_mcause = 32'h0;
    m_mip    = 32'h0;
    m_cycle  = 64'h0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // Returns the interrupt cause the model would take now, or 0 for none.
  function automatic logic [31:0] m_cause_now();
    if (instr_valid && m_status[3] && m_mie[11] && m_mip[11]) return 32'h8000_000B;
    if (instr_valid && m_status[3] && m_mie[7] && m_mip[7])   return 32'h8000_0007;
    return 32'h0;
  endfunction

  // Driver tasks
  task automatic drive(input logic wr, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] wd);
    csr_rd      = 1'b1;
    csr_wr      = wr;
    csr_op      = op;
    csr_addr    = addr;
    csr_wdata   = wd;
    instr_valid = 1'b1;
  endtask

  // Scoreboard step: compare at the falling edge, then advance the model
  // across the rising edge with the inputs that were presented.
  task automatic tick();
    logic [31:0] old_v;
    logic [31:0] nv;
    logic [31:0] cause;
    logic [31:0] tgt;
    logic        exp_taken;
    logic        old_mpie;
    logic [63:0] nxt;
    @(negedge clk);
    old_v = m_read(csr_addr);
    cause = m_cause_now();
    tgt   = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0]) tgt = tgt + 32'd4 * (cause & 32'h7FFF_FFFF);
    exp_taken = (cause != 0) || (instr_valid && is_mret);
    if (cause == 0) tgt = m_mepc;
    check("rdata", csr_rdata, old_v);
    check("epc_taken", {31'b0, epc_taken}, {31'b0, exp_taken});
    if (exp_taken) check("epc_out", epc_out, tgt);
    @(posedge clk);
    nxt = m_cycle + 64'd1;
    old_mpie = m_status[7];
    if (cause != 0) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = cause;
      m_status = 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
    end else begin
      if (csr_wr && instr_valid && csr_op != 2'b00) begin
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = old_v | csr_wdata;
          default: nv = old_v & ~csr_wdata;
        endcase
        case (csr_addr)
          12'h300: m_status = 32'h1800 | (nv & 32'h88);
          12'h304: m_mie    = nv & 32'h880;
          12'h305: m_mtvec  = nv & ~32'h2;
          12'h341: m_mepc   = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: nxt[31:0]  = nv;
          12'hB80: nxt[63:32] = nv;
          default: ;
        endcase
      end
      if (instr_valid && is_mret) m_status = 32'h1880 | (old_mpie ? 32'h8 : 32'h0);
    end
    m_cycle = nxt;
    m_mip   = (timer_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
    #1;
  endtask

  logic [11:0] addr_tbl [11];

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                 12'hB00, 12'hB80, 12'h7C0, 12'h301, 12'hF14};
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    csr_rd = 0; csr_wr = 0; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0;
    pc = 0; instr_valid = 0; is_mret = 0; timer_irq = 0; ext_irq = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mstatus", csr_rdata, 32'h0000_1800);
    check("rst_taken", {31'b0, epc_taken}, 32'h0);
    rst_n = 1'b1;

    // Reset release values and first counter step
    drive(0, 2'b00, 12'hB00, 0);
    #1 check("mcycle_first", csr_rdata, 32'h0);
    tick();
    #1 check("mcycle_second", csr_rdata, 32'h1);
    csr_addr = 12'h300;
    #1 check("mstatus_rst", csr_rdata, 32'h0000_1800);
    csr_addr = 12'h305;
    #1 check("mtvec_rst", csr_rdata, MTVEC_RST);
    tick();

    // mtvec bit 1 forced to zero
    drive(1, 2'b01, 12'h305, 32'hFFFF_FFFF);
    #1 check("mtvec_old", csr_rdata, MTVEC_RST);
    tick();
    drive(0, 2'b00, 12'h305, 0);
    #1 check("mtvec_mask", csr_rdata, 32'hFFFF_FFFD);
    tick();

    // mie set then clear
    drive(1, 2'b10, 12'h304, 32'h880);
    #1 check("mie_set_old", csr_rdata, 32'h0);
    tick();
    drive(1, 2'b11, 12'h304, 32'h080);
    #1 check("mie_clr_old", csr_rdata, 32'h880);
    tick();
    drive(0, 2'b00, 12'h304, 0);
    #1 check("mie_after", csr_rdata, 32'h800);
    tick();

    // Timer trap in direct mode with a suppressed write
    drive(1, 2'b01, 12'h305, 32'h300); tick();
    drive(1, 2'b01, 12'h304, 32'h080); tick();
    drive(1, 2'b10, 12'h300, 32'h8);   tick();
    pc = 32'h100; timer_irq = 1'b1;
    drive(0, 2'b00, 12'h300, 0);
    #1 check("tmr_no_trap_yet", {31'b0, epc_taken}, 32'h0);
    tick();
    drive(1, 2'b01, 12'h342, 32'h1234);
    #1 check("tmr_taken", {31'b0, epc_taken}, 32'h1);
    check("tmr_target", epc_out, 32'h300);
    tick();
    timer_irq = 1'b0;
    drive(0, 2'b00, 12'h341, 0);
    #1 check("tmr_mepc", csr_rdata, 32'h100);
    csr_addr = 12'h342;
    #1 check("tmr_mcause", csr_rdata, 32'h8000_0007);
    csr_addr = 12'h300;
    #1 check("tmr_mstatus", csr_rdata, 32'h1880);
    tick();

    // External beats timer, vectored mode, then mret
    drive(1, 2'b01, 12'h305, 32'h201); tick();
    drive(1, 2'b01, 12'h304, 32'h880); tick();
    drive(1, 2'b10, 12'h300, 32'h8);   tick();
    pc = 32'h200; ext_irq = 1'b1; timer_irq = 1'b1;
    drive(0, 2'b00, 12'h300, 0);
    tick();
    #1 check("ext_taken", {31'b0, epc_taken}, 32'h1);
    check("ext_target", epc_out, 32'h22C);
    tick();
    ext_irq = 1'b0; timer_irq = 1'b0;
    drive(0, 2'b00, 12'h342, 0);
    #1 check("ext_mcause", csr_rdata, 32'h8000_000B);
    tick();
    pc = 32'h500; is_mret = 1'b1;
    drive(0, 2'b00, 12'h341, 0);
    #1 check("mret_taken", {31'b0, epc_taken}, 32'h1);
    check("mret_target", epc_out, 32'h200);
    tick();
    is_mret = 1'b0;
    drive(0, 2'b00, 12'h300, 0);
    #1 check("mret_mstatus", csr_rdata, 32'h1888);
    tick();

    // Counter carry and half writes
    drive(1, 2'b01, 12'hB80, 32'h5); tick();
    drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drive(0, 2'b00, 12'hB00, 0);
    #1 check("cyc_lo_ff", csr_rdata, 32'hFFFF_FFFF);
    csr_addr = 12'hB80;
    #1 check("cyc_hi_5", csr_rdata, 32'h5);
    tick();
    csr_addr = 12'hB00;
    #1 check("cyc_lo_wrap", csr_rdata, 32'h0);
    csr_addr = 12'hB80;
    #1 check("cyc_hi_carry", csr_rdata, 32'h6);
    tick();
    drive(1, 2'b01, 12'hB80, 32'h77); tick();
    drive(0, 2'b00, 12'hB00, 0);
    #1 check("cyc_lo_counts", csr_rdata, 32'h2);
    csr_addr = 12'hB80;
    #1 check("cyc_hi_written", csr_rdata, 32'h77);
    tick();
    drive(1, 2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drive(0, 2'b00, 12'hB00, 0);
    tick();
    #1 check("cyc64_wrap_lo", csr_rdata, 32'h0);
    csr_addr = 12'hB80;
    #1 check("cyc64_wrap_hi", csr_rdata, 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            addr_tbl[$urandom_range(0, 10)], $urandom);
      instr_valid = ($urandom_range(0, 7) != 0);
      is_mret     = ($urandom_range(0, 11) == 0);
      pc          = $urandom;
      if ($urandom_range(0, 5) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 5) == 0) ext_irq   = ~ext_irq;
      tick();
    end
    is_mret = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;

    // Asynchronous reset while a trap is pending
    drive(1, 2'b01, 12'h305, 32'h300); tick();
    drive(1, 2'b01, 12'h304, 32'h800); tick();
    drive(1, 2'b01, 12'h300, 32'h8);   tick();
    ext_irq = 1'b1; pc = 32'h40;
    drive(0, 2'b00, 12'h300, 0);
    tick();
    drive(1, 2'b01, 12'h342, 32'h55);
    #1 check("pre_rst_taken", {31'b0, epc_taken}, 32'h1);
    rst_n = 1'b0;
    #1 check("arst_taken", {31'b0, epc_taken}, 32'h0);
    csr_addr = 12'h300;
    #1 check("arst_mstatus", csr_rdata, 32'h0000_1800);
    csr_addr = 12'h304;
    #1 check("arst_mie", csr_rdata, 32'h0);
    csr_addr = 12'h305;
    #1 check("arst_mtvec", csr_rdata, MTVEC_RST);
    csr_addr = 12'h341;
    #1 check("arst_mepc", csr_rdata, 32'h0);
    csr_addr = 12'h342;
    #1 check("arst_mcause", csr_rdata, 32'h0);
    csr_addr = 12'hB00;
    #1 check("arst_mcycle", csr_rdata, 32'h0);
    model_reset();
    ext_irq = 1'b0;
    @(posedge clk);
    #1;
    csr_addr = 12'h344;
    #1 check("held_mip", csr_rdata, 32'h0);
    rst_n = 1'b1;
    drive(0, 2'b00, 12'hB00, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
